byte_addr_load_unit: RTL and testbench

Load-side byte-to-word address translator: the inverse of the word-to-byte (<<2) offset path.
- Accepts a byte address plus access size and converts it to a word index (addr >> 2).
- Issues one or two word reads to a synchronous word-addressed memory, then extracts, merges and extends the addressed bytes.
- Sits between the MEM stage and data memory; handles byte, half and word loads, including accesses that cross a word boundary.

---
 rtl/byte_addr_load_unit.sv | 135 +++++++++++++
 tb/tb_byte_addr_load_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_addr_load_unit.sv
// rtl/byte_addr_load_unit.sv - byte-address load unit: word reads, lane extract/merge, sign/zero extend
// Define MISALIGN_TRAP_EN to reject misaligned half/word loads instead of splitting them.
module byte_addr_load_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  output logic              MemRdEn,
  output logic [ADDR_W-3:0] MemAddr,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] RespData,
  output logic              RespErr
);

  typedef enum logic [2:0] {IDLE, ISSUE0, CAP0, ISSUE1, CAP1, RESP} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-3:0]   word_q;
  logic [1:0]          off_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [DATA_W-1:0]   lo_q;
  logic                req_fire;
  logic                req_bad;
  logic                crossing;

  // Shift the little-endian byte pair so the addressed byte sits in lane 0, then extend.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W-1:0] lo,
                                              input logic [1:0] off,
                                              input logic [1:0] size,
                                              input logic sgn);
    logic [2*DATA_W-1:0] t;
    logic [DATA_W-1:0]   r;
    t = {hi, lo} >> {off, 3'b000};
    case (size)
      2'b00:   r = {{24{sgn & t[7]}}, t[7:0]};
      2'b01:   r = {{16{sgn & t[15]}}, t[15:0]};
      default: r = t[31:0];
    endcase
    return r;
  endfunction

  assign req_fire = ReqValid && ReqReady;
  assign crossing = ((size_q == 2'b01) && (off_q == 2'b11)) ||
                    ((size_q == 2'b10) && (off_q != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign req_bad = (ReqSize == 2'b11) ||
                   ((ReqSize == 2'b01) && ReqAddr[0]) ||
                   ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));
`else
  assign req_bad = (ReqSize == 2'b11);
`endif

  always_comb begin
    state_nx  = state;
    ReqReady  = 1'b0;
    MemRdEn   = 1'b0;
    RespValid = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_nx = req_bad ? RESP : ISSUE0;
      end
      ISSUE0: begin
        MemRdEn  = 1'b1;
        state_nx = CAP0;
      end
      CAP0:   state_nx = crossing ? ISSUE1 : RESP;
      ISSUE1: begin
        MemRdEn  = 1'b1;
        state_nx = CAP1;
      end
      CAP1:   state_nx = RESP;
      RESP: begin
        RespValid = 1'b1;
        if (RespReady) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      word_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      lo_q     <= '0;
      MemAddr  <= '0;
      RespData <= '0;
      RespErr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            word_q   <= ReqAddr[ADDR_W-1:2];
            off_q    <= ReqAddr[1:0];
            size_q   <= ReqSize;
            sgn_q    <= ReqSigned;
            RespErr  <= req_bad;
            RespData <= '0;
            // Rejected requests never touch memory, so MemAddr keeps its old value.
            if (!req_bad) MemAddr <= ReqAddr[ADDR_W-1:2];
          end
        end
        CAP0: begin
          lo_q <= MemRdData;
          if (crossing) MemAddr <= word_q + 1'b1;
          else          RespData <= merge('0, MemRdData, off_q, size_q, sgn_q);
        end
        CAP1: RespData <= merge(MemRdData, lo_q, off_q, size_q, sgn_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_addr_load_unit.sv
// tb/tb_byte_addr_load_unit.sv - directed table-driven bench for byte_addr_load_unit
module tb_byte_addr_load_unit;

  logic        Clk;
  logic        Rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic        MemRdEn;
  logic [29:0] MemAddr;
  logic [31:0] MemRdData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespData;
  logic        RespErr;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  logic [29:0] rd_log [0:255];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] data;
    logic        err;
    int          nrd;
    logic [29:0] a0;
    logic [29:0] a1;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [12];

  byte_addr_load_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned),
    .MemRdEn(MemRdEn), .MemAddr(MemAddr), .MemRdData(MemRdData),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespErr(RespErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'd4:          return 32'hC4332211;
      30'd5:          return 32'h88776655;
      30'h3FFFFFFF:   return 32'hAABBCCDD;
      30'd0:          return 32'h11223344;
      default:        return 32'hDEADBEEF;
    endcase
  endfunction

  // Synchronous word memory plus a log of every read strobe.
  always @(posedge Clk) begin
    if (MemRdEn) begin
      MemRdData <= mem_word(MemAddr);
      if (rd_cnt < 256) rd_log[rd_cnt] <= MemAddr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int base;
    int lat;
    @(negedge Clk);
    ReqValid  = 1'b1;
    ReqAddr   = v.addr;
    ReqSize   = v.size;
    ReqSigned = v.sgn;
    base      = rd_cnt;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    lat = 1;
    while (!RespValid && lat < 20) begin
      @(posedge Clk);
      #1 lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(v.lat));
    check({name, " data"}, RespData, v.data);
    check({name, " err"}, 32'(RespErr), 32'(v.err));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge Clk);
      #1;
      check({name, " hold valid"}, 32'(RespValid), 32'd1);
      check({name, " hold data"}, RespData, v.data);
      check({name, " hold reqready"}, 32'(ReqReady), 32'd0);
    end
    @(negedge Clk);
    RespReady = 1'b1;
    @(posedge Clk);
    #1 RespReady = 1'b0;
    check({name, " valid drop"}, 32'(RespValid), 32'd0);
    check({name, " ready back"}, 32'(ReqReady), 32'd1);
    check({name, " reads"}, 32'(rd_cnt - base), 32'(v.nrd));
    if (v.nrd >= 1) check({name, " addr0"}, 32'(rd_log[base]), 32'(v.a0));
    if (v.nrd >= 2) check({name, " addr1"}, 32'(rd_log[base+1]), 32'(v.a1));
  endtask

  initial begin
    int base;
    Rst_n     = 1'b0;
    ReqValid  = 1'b0;
    ReqAddr   = '0;
    ReqSize   = '0;
    ReqSigned = 1'b0;
    RespReady = 1'b0;

    vecs[0]  = '{32'h13, 2'b00, 1'b1, 32'hFFFFFFC4, 1'b0, 1, 30'd4, 30'd0, 3, 0};
    vecs[1]  = '{32'h14, 2'b10, 1'b0, 32'h88776655, 1'b0, 1, 30'd5, 30'd0, 3, 4};
    vecs[2]  = '{32'h17, 2'b00, 1'b0, 32'h00000088, 1'b0, 1, 30'd5, 30'd0, 3, 0};
`ifdef MISALIGN_TRAP_EN
    vecs[3]  = '{32'h12, 2'b10, 1'b0, 32'h0, 1'b1, 0, 30'd0, 30'd0, 1, 0};
    vecs[4]  = '{32'h13, 2'b01, 1'b0, 32'h0, 1'b1, 0, 30'd0, 30'd0, 1, 0};
    vecs[5]  = '{32'h11, 2'b01, 1'b1, 32'h0, 1'b1, 0, 30'd0, 30'd0, 1, 0};
    vecs[6]  = '{32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, 1'b1, 0, 30'd0, 30'd0, 1, 0};
`else
    vecs[3]  = '{32'h12, 2'b10, 1'b0, 32'h6655C433, 1'b0, 2, 30'd4, 30'd5, 5, 0};
    vecs[4]  = '{32'h13, 2'b01, 1'b0, 32'h000055C4, 1'b0, 2, 30'd4, 30'd5, 5, 0};
    vecs[5]  = '{32'h11, 2'b01, 1'b1, 32'h00003322, 1'b0, 1, 30'd4, 30'd0, 3, 0};
    vecs[6]  = '{32'hFFFFFFFE, 2'b10, 1'b0, 32'h3344AABB, 1'b0, 2, 30'h3FFFFFFF, 30'd0, 5, 0};
`endif
    vecs[7]  = '{32'h10, 2'b11, 1'b0, 32'h0, 1'b1, 0, 30'd0, 30'd0, 1, 0};
    vecs[8]  = '{32'h16, 2'b01, 1'b1, 32'hFFFF8877, 1'b0, 1, 30'd5, 30'd0, 3, 0};
    vecs[9]  = '{32'h12, 2'b01, 1'b1, 32'hFFFFC433, 1'b0, 1, 30'd4, 30'd0, 3, 0};
    vecs[10] = '{32'h10, 2'b10, 1'b1, 32'hC4332211, 1'b0, 1, 30'd4, 30'd0, 3, 0};
    vecs[11] = '{32'h13, 2'b00, 1'b0, 32'h000000C4, 1'b0, 1, 30'd4, 30'd0, 3, 0};

    repeat (2) @(posedge Clk);
    #1;
    check("reset memrden", 32'(MemRdEn), 32'd0);
    check("reset memaddr", 32'(MemAddr), 32'd0);
    check("reset respvalid", 32'(RespValid), 32'd0);
    check("reset respdata", RespData, 32'd0);
    check("reset resperr", 32'(RespErr), 32'd0);
    check("reset reqready", 32'(ReqReady), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the second read of a crossing word load is being issued.
    @(negedge Clk);
    ReqValid  = 1'b1;
    ReqAddr   = 32'h12;
    ReqSize   = 2'b10;
    ReqSigned = 1'b0;
    base      = rd_cnt;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
`ifndef MISALIGN_TRAP_EN
    check("issue1 memrden", 32'(MemRdEn), 32'd1);
    check("issue1 memaddr", 32'(MemAddr), 32'd5);
`endif
    #1 Rst_n = 1'b0;
    #1;
    check("async rst memrden", 32'(MemRdEn), 32'd0);
    check("async rst respvalid", 32'(RespValid), 32'd0);
    check("async rst reqready", 32'(ReqReady), 32'd1);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("post rst reqready", 32'(ReqReady), 32'd1);
    check("post rst respvalid", 32'(RespValid), 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst aborted reads", 32'(rd_cnt - base), 32'd0);
`else
    check("rst aborted reads", 32'(rd_cnt - base), 32'd1);
`endif
    run_vec(vecs[0], "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
